// File: rtl/fp_mul_unit.sv
// Iterative 32x32 shift-add multiplier, one multiplier bit per clock, LSB first.
// Signed mode multiplies magnitudes and negates the 64-bit result when the operand signs differ.
module fp_mul_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        isSigned,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        done,
    output logic [31:0] prodHi,
    output logic [31:0] prodLo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic [63:0] prod_q, prod_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [32:0] step_sum_s;
    logic [63:0] step_acc_s;

    // Magnitude of an operand; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) begin
            mag32 = ~v + 32'd1;
        end else begin
            mag32 = v;
        end
    endfunction

    // Next-state, datapath step and product load.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        prod_d     = prod_q;
        // acc holds {partial high, remaining multiplier bits}; add on LSB, then shift right.
        step_sum_s = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        step_acc_s = {step_sum_s, acc_q[31:1]};
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d = mag32(opA, isSigned);
                    acc_d   = {32'd0, mag32(opB, isSigned)};
                    neg_d   = isSigned & (opA[31] ^ opB[31]);
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = step_acc_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    prod_d  = neg_q ? (~step_acc_s + 64'd1) : step_acc_s;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            mcand_q <= 32'd0;
            acc_q   <= 64'd0;
            neg_q   <= 1'b0;
            prod_q  <= 64'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign prodHi = prod_q[63:32];
    assign prodLo = prod_q[31:0];

endmodule

// File: tb/tb_fp_mul_unit.sv
// Self-checking bench for fp_mul_unit: directed corner cases plus random operands
// against a plain 64-bit arithmetic reference.
module tb_fp_mul_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        isSigned;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] prodHi;
    logic [31:0] prodLo;

    int n_cmp;
    int n_bad;
    int cyc;

    fp_mul_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .isSigned (isSigned),
        .opA      (opA),
        .opB      (opB),
        .busy     (busy),
        .done     (done),
        .prodHi   (prodHi),
        .prodLo   (prodLo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // One complete multiply; optionally fires an ignored start with other operands at RUN cycle 10.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit inj);
        logic [63:0] exp;
        int busy_cnt;
        bit got;
        exp = ref_mul(a, b, s);
        start = 1'b1; opA = a; opB = b; isSigned = s;
        @(posedge clk); #1;
        start = 1'b0; opA = $urandom; opB = $urandom; isSigned = 1'($urandom);
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            if (busy) busy_cnt++;
            if (inj && i == 10) begin
                start = 1'b1; opA = ~a; opB = b + 32'd3; isSigned = ~s;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                check_val({tag, "_latency"}, 64'(i), 64'd32);
                check_val({tag, "_prod"}, {prodHi, prodLo}, exp);
                check_val({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            end
        end
        if (!got) check_val({tag, "_timeout"}, 64'd0, 64'd1);
        check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        @(posedge clk); #1;
        check_val({tag, "_done_pulse_len"}, 64'(done), 64'd0);
        check_val({tag, "_hold"}, {prodHi, prodLo}, exp);
    endtask

    task automatic count_dones(input string tag, input int ncyc);
        int nd;
        nd = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check_val(tag, 64'(nd), 64'd0);
    endtask

    initial begin
        int t1;
        int t2;
        bit got;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        n_cmp = 0; n_bad = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; isSigned = 1'b0; opA = 32'd0; opB = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_prod", {prodHi, prodLo}, 64'd0);
        reset = 1'b0;

        run_op("u7x6", 32'h0000_0007, 32'h0000_0006, 1'b0, 1'b0);
        run_op("s_m3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0);
        run_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run_op("s_m1xmin", 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        run_op("zero_b", 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
        run_op("zero_a", 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_val("ref_u_max", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);

        run_op("inj", 32'h0001_2345, 32'hFFFF_0011, 1'b1, 1'b1);
        count_dones("inj_no_extra_done", 40);

        for (int k = 0; k < 16; k++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            run_op("rand", ra, rb, rs, 1'b0);
        end

        // Back-to-back: start presented during DONE.
        start = 1'b1; opA = 32'h0000_1234; opB = 32'hFFFF_FF00; isSigned = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0; t1 = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (done) begin got = 1'b1; t1 = cyc; end
        end
        if (!got) check_val("b2b_first_timeout", 64'd0, 64'd1);
        check_val("b2b_prod1", {prodHi, prodLo}, ref_mul(32'h0000_1234, 32'hFFFF_FF00, 1'b1));
        start = 1'b1; opA = 32'hCAFE_0001; opB = 32'h0BAD_F00D; isSigned = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("b2b_run_after_done", 64'(busy), 64'd1);
        got = 1'b0; t2 = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (done) begin got = 1'b1; t2 = cyc; end
        end
        if (!got) check_val("b2b_second_timeout", 64'd0, 64'd1);
        check_val("b2b_spacing", 64'(t2 - t1), 64'd33);
        check_val("b2b_prod2", {prodHi, prodLo}, ref_mul(32'hCAFE_0001, 32'h0BAD_F00D, 1'b0));

        // Reset asserted at RUN cycle 16.
        @(posedge clk); #1;
        start = 1'b1; opA = 32'h7FFF_FFFF; opB = 32'h0000_0003; isSigned = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check_val("mid_busy_before_rst", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_val("rst_async_busy", 64'(busy), 64'd0);
        check_val("rst_async_done", 64'(done), 64'd0);
        check_val("rst_async_prod", {prodHi, prodLo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        count_dones("rst_no_done", 40);
        check_val("rst_prod_stays_zero", {prodHi, prodLo}, 64'd0);
        run_op("after_rst", 32'h0000_0009, 32'hFFFF_FFF9, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
